// File: rtl/flag_sync_hs.sv
// ============================================================================
// Module : flag_sync_hs
// Multi-channel toggle-handshake pulse synchronizer (clkA -> clkB) with
// per-channel busy tracking and a saturating count of rejected events.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flag_sync_hs #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                clkA,
  input  logic                a_rst_n,
  input  logic                clkB,
  input  logic                b_rst_n,
  input  logic [CHANNELS-1:0] pulse_in_a,
  input  logic                clr_cnt_a,
  output logic [CHANNELS-1:0] busy_a,
  output logic [CHANNELS-1:0] drop_a,
  output logic [CNT_W-1:0]    drop_cnt_a,
  output logic [CHANNELS-1:0] pulse_out_b
);

  // Six extra bits hold a full 32-channel popcount on top of the counter.
  localparam int               SUM_W   = CNT_W + 6;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  // clkA domain
  logic [CHANNELS-1:0]                  req_tgl_q;
  logic [CHANNELS-1:0]                  req_tgl_d;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] ack_sync_q;
  logic [CHANNELS-1:0]                  busy_q;
  logic [CHANNELS-1:0]                  busy_d;
  logic [CHANNELS-1:0]                  drop_q;
  logic [CHANNELS-1:0]                  drop_d;
  logic [CNT_W-1:0]                     cnt_q;
  logic [CNT_W-1:0]                     cnt_d;
  logic [CHANNELS-1:0]                  w_accept;
  logic [SUM_W-1:0]                     w_drop_sum;

  // clkB domain
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] req_sync_q;
  logic [CHANNELS-1:0]                  ack_tgl_q;

  always_comb begin
    w_accept   = pulse_in_a & ~busy_q;
    req_tgl_d  = req_tgl_q ^ w_accept;
    busy_d     = req_tgl_d ^ ack_sync_q[SYNC_STAGES-1];
    drop_d     = pulse_in_a & busy_q;
    w_drop_sum = {{(SUM_W-CNT_W){1'b0}}, cnt_q};
    for (int i = 0; i < CHANNELS; i++) begin
      w_drop_sum = w_drop_sum + SUM_W'(drop_d[i]);
    end
    // A clear wins over drops landing in the same cycle.
    if (clr_cnt_a) begin
      cnt_d = '0;
    end else if (w_drop_sum > CNT_MAX) begin
      cnt_d = '1;
    end else begin
      cnt_d = w_drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clkA or negedge a_rst_n) begin
    if (!a_rst_n) begin
      req_tgl_q  <= '0;
      ack_sync_q <= '0;
      busy_q     <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
    end else begin
      req_tgl_q  <= req_tgl_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
    end
  end

  // The edge flop doubles as the acknowledge toggle returned to clkA.
  always_ff @(posedge clkB or negedge b_rst_n) begin
    if (!b_rst_n) begin
      req_sync_q <= '0;
      ack_tgl_q  <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
      ack_tgl_q  <= req_sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_out_b = req_sync_q[SYNC_STAGES-1] ^ ack_tgl_q;
  assign busy_a      = busy_q;
  assign drop_a      = drop_q;
  assign drop_cnt_a  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_flag_sync_hs.sv
// ============================================================================
// Module : tb_flag_sync_hs
// Self-checking bench for flag_sync_hs: vector table plus strobe scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_flag_sync_hs;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = 4;

  logic          clkA       = 1'b0;
  logic          clkB       = 1'b0;
  logic          a_rst_n    = 1'b0;
  logic          b_rst_n    = 1'b0;
  logic [CH-1:0] pulse_in_a = '0;
  logic          clr_cnt_a  = 1'b0;
  logic [CH-1:0] busy_a;
  logic [CH-1:0] drop_a;
  logic [CW-1:0] drop_cnt_a;
  logic [CH-1:0] pulse_out_b;

  int  halfA = 5;
  int  halfB = 7;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  sb_q[$];
  int  n_strobe [CH];
  time t_strobe [CH];
  logic [CH-1:0] prev_b = '0;
  int  mon_idx;

  typedef struct {
    logic [CH-1:0] pulse;
    logic          clr;
    logic [CH-1:0] acc;
    logic [CH-1:0] busy;
    logic [CH-1:0] drop;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl [14];
  vec_t rst_row;

  flag_sync_hs #(
    .CHANNELS   (CH),
    .SYNC_STAGES(SS),
    .CNT_W      (CW)
  ) dut (
    .clkA       (clkA),
    .a_rst_n    (a_rst_n),
    .clkB       (clkB),
    .b_rst_n    (b_rst_n),
    .pulse_in_a (pulse_in_a),
    .clr_cnt_a  (clr_cnt_a),
    .busy_a     (busy_a),
    .drop_a     (drop_a),
    .drop_cnt_a (drop_cnt_a),
    .pulse_out_b(pulse_out_b)
  );

  initial forever #(halfA) clkA = ~clkA;
  initial forever #(halfB) clkB = ~clkB;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Each strobe must be one clkB cycle wide and match a pending accepted event.
  always @(negedge clkB) begin
    for (int i = 0; i < CH; i++) begin
      if (pulse_out_b[i]) begin
        if (prev_b[i]) begin
          n_tests++;
          n_fail++;
          $display("FAIL strobe_width ch%0d: high for 2+ clkB cycles, expected 1", i);
        end else begin
          mon_idx = -1;
          foreach (sb_q[j]) if (mon_idx < 0 && sb_q[j] == i) mon_idx = j;
          n_tests++;
          if (mon_idx < 0) begin
            n_fail++;
            $display("FAIL sb_unexpected ch%0d: pulse_out_b=1, expected 0 (no pending event)", i);
          end else begin
            sb_q.delete(mon_idx);
          end
          n_strobe[i]++;
          t_strobe[i] = $time - time'(halfB);
        end
      end
    end
    prev_b = pulse_out_b;
  end

  task automatic do_reset(input int ha, input int hb);
    a_rst_n    = 1'b0;
    b_rst_n    = 1'b0;
    pulse_in_a = '0;
    clr_cnt_a  = 1'b0;
    halfA      = ha;
    halfB      = hb;
    repeat (4) @(posedge clkB);
    repeat (4) @(posedge clkA);
    #1;
    sb_q.delete();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
  endtask

  task automatic apply_row(input vec_t v, input string tag, input int r);
    pulse_in_a = v.pulse;
    clr_cnt_a  = v.clr;
    for (int i = 0; i < CH; i++) if (v.acc[i]) sb_q.push_back(i);
    @(posedge clkA);
    #1;
    check($sformatf("%s row%0d busy_a", tag, r), int'(busy_a), int'(v.busy));
    check($sformatf("%s row%0d drop_a", tag, r), int'(drop_a), int'(v.drop));
    check($sformatf("%s row%0d drop_cnt_a", tag, r), int'(drop_cnt_a), int'(v.cnt));
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((sb_q.size() != 0 || busy_a != '0) && k < budget) begin
      @(posedge clkA);
      #1;
      k++;
    end
    check({name, " drained (pending=", $sformatf("%0d", sb_q.size()), ")"},
          (sb_q.size() == 0 && busy_a == '0) ? 1 : 0, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t_acc;
    time t_fall;
    int  base;
    int  k;
    int  drops;

    rst_row = '{4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 4'd0};
    //              pulse  clr   acc   busy  drop  cnt
    tbl[0]  = '{4'hC, 1'b0, 4'hC, 4'hC, 4'h0, 4'd0};
    tbl[1]  = '{4'hC, 1'b0, 4'h0, 4'hC, 4'hC, 4'd2};
    tbl[2]  = '{4'hC, 1'b0, 4'h0, 4'hC, 4'hC, 4'd4};
    tbl[3]  = '{4'hC, 1'b0, 4'h0, 4'hC, 4'hC, 4'd6};
    tbl[4]  = '{4'hC, 1'b0, 4'h0, 4'hC, 4'hC, 4'd8};
    tbl[5]  = '{4'hC, 1'b0, 4'h0, 4'hC, 4'hC, 4'd10};
    tbl[6]  = '{4'hC, 1'b0, 4'h0, 4'hC, 4'hC, 4'd12};
    tbl[7]  = '{4'hC, 1'b0, 4'h0, 4'hC, 4'hC, 4'd14};
    tbl[8]  = '{4'hC, 1'b0, 4'h0, 4'hC, 4'hC, 4'd15};
    tbl[9]  = '{4'hC, 1'b0, 4'h0, 4'hC, 4'hC, 4'd15};
    tbl[10] = '{4'hC, 1'b1, 4'h0, 4'hC, 4'hC, 4'd0};
    tbl[11] = '{4'h4, 1'b0, 4'h0, 4'hC, 4'h4, 4'd1};
    tbl[12] = '{4'h0, 1'b0, 4'h0, 4'hC, 4'h0, 4'd1};
    tbl[13] = '{4'h0, 1'b1, 4'h0, 4'hC, 4'h0, 4'd0};

    // Scenario 1: outputs stay quiet while both resets are held.
    repeat (3) @(posedge clkB);
    @(posedge clkA);
    #1;
    for (int r = 0; r < 3; r++) apply_row(rst_row, "s1", r);
    check("s1 pulse_out_b in reset", int'(pulse_out_b), 0);

    // Scenario 2: slow clkA, fast clkB.
    do_reset(20, 3);
    base       = n_strobe[0];
    pulse_in_a = 4'b0001;
    sb_q.push_back(0);
    @(posedge clkA);
    t_acc = $time;
    #1;
    pulse_in_a = '0;
    check("s2 busy_a[0] after accept", int'(busy_a[0]), 1);
    check("s2 drop_a after accept", int'(drop_a), 0);
    k = 0;
    while (n_strobe[0] == base && k < 100) begin
      @(posedge clkB);
      k++;
    end
    check("s2 strobe count", n_strobe[0] - base, 1);
    check_range("s2 forward latency ns", int'(t_strobe[0] - t_acc), 6, 24);
    k = 0;
    while (busy_a[0] && k < 20) begin
      @(posedge clkA);
      #1;
      k++;
    end
    t_fall = $time - 1;
    check("s2 busy_a[0] cleared", int'(busy_a[0]), 0);
    check_range("s2 busy fall after strobe ns", int'(t_fall - t_strobe[0]), 0, 160);
    drain("s2", 50);
    check("s2 drop_cnt_a", int'(drop_cnt_a), 0);
    check("s2 total strobes", n_strobe[0] - base, 1);

    // Scenario 3: fast clkA, slow clkB, input held for ten cycles.
    do_reset(3, 20);
    base       = n_strobe[1];
    drops      = 0;
    pulse_in_a = 4'b0010;
    sb_q.push_back(1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clkA);
      #1;
      if (c == 0) check("s3 busy_a[1] after accept", int'(busy_a[1]), 1);
      if (drop_a[1]) drops++;
    end
    pulse_in_a = '0;
    @(posedge clkA);
    #1;
    if (drop_a[1]) drops++;
    check("s3 drop_a[1] pulse count", drops, 9);
    check("s3 drop_cnt_a", int'(drop_cnt_a), 9);
    drain("s3", 200);
    check("s3 strobes ch1", n_strobe[1] - base, 1);

    // Scenario 4: simultaneous drops, saturation, clear priority.
    do_reset(3, 40);
    for (int r = 0; r < 14; r++) apply_row(tbl[r], "s4", r);
    pulse_in_a = '0;
    clr_cnt_a  = 1'b0;
    drain("s4", 400);

    // Scenario 5: re-arm in the first idle cycle.
    do_reset(5, 7);
    base       = n_strobe[0];
    pulse_in_a = 4'b0001;
    sb_q.push_back(0);
    @(posedge clkA);
    #1;
    pulse_in_a = '0;
    k = 0;
    do begin
      @(posedge clkA);
      #1;
      k++;
    end while (busy_a[0] && k < 100);
    check("s5 busy_a[0] released", int'(busy_a[0]), 0);
    pulse_in_a = 4'b0001;
    sb_q.push_back(0);
    @(posedge clkA);
    #1;
    pulse_in_a = '0;
    check("s5 re-accept busy_a[0]", int'(busy_a[0]), 1);
    check("s5 re-accept drop_a", int'(drop_a), 0);
    drain("s5", 100);
    check("s5 strobes ch0", n_strobe[0] - base, 2);
    check("s5 drop_cnt_a", int'(drop_cnt_a), 0);

    // Scenario 6: both resets asserted while ch0 is in flight.
    do_reset(5, 7);
    pulse_in_a = 4'b0001;
    sb_q.push_back(0);
    @(posedge clkA);
    #1;
    pulse_in_a = '0;
    check("s6 busy_a[0] before reset", int'(busy_a[0]), 1);
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("s6 busy_a in reset", int'(busy_a), 0);
    check("s6 drop_a in reset", int'(drop_a), 0);
    check("s6 drop_cnt_a in reset", int'(drop_cnt_a), 0);
    check("s6 pulse_out_b in reset", int'(pulse_out_b), 0);
    base = n_strobe[0];
    repeat (4) @(posedge clkB);
    @(posedge clkA);
    #1;
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    repeat (30) @(posedge clkA);
    #1;
    check("s6 strobes after release", n_strobe[0] - base, 0);
    check("s6 busy_a after release", int'(busy_a), 0);
    pulse_in_a = 4'b0001;
    sb_q.push_back(0);
    @(posedge clkA);
    #1;
    pulse_in_a = '0;
    drain("s6", 100);
    check("s6 strobes for new event", n_strobe[0] - base, 1);

    repeat (20) @(posedge clkA);
    check("final pending events", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
